// File: rtl/sm_mac_pkg.sv
// Shared state type and operand-code helpers for the sign-magnitude MAC.
package sm_mac_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} mac_state_e;

  function automatic logic is_zero_code(logic [63:0] v);
    return v == 64'd0;
  endfunction

  // UNIT is the negative-zero pattern: sign bit set, magnitude all zero.
  function automatic logic is_unit_code(logic [63:0] v, int unsigned w);
    return v == (64'd1 << (w - 1));
  endfunction

  function automatic logic acc_width_ok(int unsigned bit_w, int unsigned acc_w);
    return (acc_w - 1) >= 2 * (bit_w - 1);
  endfunction

endpackage

// File: rtl/sm_mult_stage.sv
// P1 of the MAC: registered sign-magnitude multiplier with zero/UNIT operand codes.
module sm_mult_stage
  import sm_mac_pkg::*;
#(
  parameter int unsigned BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     en,
  input  logic [BIT-1:0]           a,
  input  logic [BIT-1:0]           b,
  input  logic                     last,
  output logic                     p_valid,
  output logic                     p_neg,
  output logic [2*(BIT-1)-1:0]     p_mag,
  output logic                     p_last
);

  localparam int unsigned MW = BIT - 1;
  localparam int unsigned PW = 2 * MW;

  logic          za, zb, ua, ub;
  logic [MW-1:0] am, bm;
  logic          neg_d;
  logic [PW-1:0] mag_d;

  always_comb begin
    am    = a[MW-1:0];
    bm    = b[MW-1:0];
    za    = is_zero_code(64'(a));
    zb    = is_zero_code(64'(b));
    ua    = is_unit_code(64'(a), BIT);
    ub    = is_unit_code(64'(b), BIT);
    neg_d = 1'b0;
    mag_d = '0;
    // Zero wins over UNIT, so only non-zero pairs reach the UNIT checks.
    if (!(za || zb)) begin
      if (ua && ub) begin
        mag_d = PW'(1) << MW;
      end else if (ua) begin
        neg_d = b[BIT-1];
        mag_d = PW'(bm) << MW;
      end else if (ub) begin
        neg_d = a[BIT-1];
        mag_d = PW'(am) << MW;
      end else begin
        neg_d = a[BIT-1] ^ b[BIT-1];
        mag_d = PW'(am) * PW'(bm);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_neg   <= 1'b0;
      p_mag   <= '0;
    end else if (flush) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_neg   <= 1'b0;
      p_mag   <= '0;
    end else begin
      p_valid <= en;
      p_last  <= en & last;
      if (en) begin
        p_neg <= neg_d;
        p_mag <= mag_d;
      end
    end
  end

endmodule

// File: rtl/sm_mac_unit.sv
// Sign-magnitude multiply-accumulate over one vector per result, with saturation.
// Optional build macro SM_MAC_RELU_EN: negative final sums are emitted as zero.
module sm_mac_unit
  import sm_mac_pkg::*;
#(
  parameter int unsigned BIT     = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned MAX_LEN = 784
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT-1:0]                 in_a,
  input  logic [BIT-1:0]                 in_b,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
  output logic                           out_ovf
);

  localparam int unsigned PW = 2 * (BIT - 1);
  localparam int unsigned SW = ACC_W + 1;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic signed [ACC_W:0] MaxPos = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MaxNeg = -MaxPos;

  if (!acc_width_ok(BIT, ACC_W)) begin : g_width_check
    $error("sm_mac_unit: ACC_W-1 must be >= 2*(BIT-1)");
  end

  mac_state_e              state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    p2_last_q, p2_last_d;
  logic                    ready_q, ready_d;
  logic                    out_valid_d, out_ovf_d;
  logic [ACC_W-1:0]        out_sum_d;
  logic [CW-1:0]           out_count_d;

  logic                    accept, end_beat;
  logic                    p_valid, p_neg, p_last;
  logic [PW-1:0]           p_mag;
  logic signed [ACC_W:0]   prod_tc, sum;
  logic [ACC_W-1:0]        acc_abs, sm_sum;

  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q && !flush;
  // The beat that fills MAX_LEN closes the vector even without in_last.
  assign end_beat = in_last || (count_q == CW'(MAX_LEN - 1));

  sm_mult_stage #(
    .BIT(BIT)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .en     (accept),
    .a      (in_a),
    .b      (in_b),
    .last   (end_beat),
    .p_valid(p_valid),
    .p_neg  (p_neg),
    .p_mag  (p_mag),
    .p_last (p_last)
  );

  always_comb begin
    prod_tc = $signed(SW'(p_mag));
    if (p_neg) prod_tc = -prod_tc;
    sum     = SW'(acc_q) + prod_tc;
    acc_abs = acc_q[ACC_W-1] ? -acc_q : acc_q;
    sm_sum  = {acc_q[ACC_W-1], acc_abs[ACC_W-2:0]};
`ifdef SM_MAC_RELU_EN
    if (acc_q[ACC_W-1]) sm_sum = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    p2_last_d   = 1'b0;
    out_valid_d = out_valid;
    out_sum_d   = out_sum;
    out_count_d = out_count;
    out_ovf_d   = out_ovf;
    if (flush) begin
      state_d     = StIdle;
      count_d     = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_count_d = '0;
      out_ovf_d   = 1'b0;
    end else begin
      if (accept) count_d = count_q + 1'b1;
      if (p_valid) begin
        p2_last_d = p_last;
        if (sum > MaxPos) begin
          acc_d = MaxPos[ACC_W-1:0];
          ovf_d = 1'b1;
        end else if (sum < MaxNeg) begin
          acc_d = MaxNeg[ACC_W-1:0];
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
      end
      if (p2_last_q) begin
        out_valid_d = 1'b1;
        out_sum_d   = sm_sum;
        out_count_d = count_q;
        out_ovf_d   = ovf_q;
      end
      unique case (state_q)
        StIdle:  if (accept) state_d = end_beat ? StDrain : StAccum;
        StAccum: if (accept && end_beat) state_d = StDrain;
        StDrain: if (p2_last_q) state_d = StDone;
        StDone: begin
          if (out_valid && out_ready) begin
            state_d     = StIdle;
            count_d     = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    ready_d = (state_d == StIdle) || (state_d == StAccum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      p2_last_q <= 1'b0;
      ready_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      p2_last_q <= p2_last_d;
      ready_q   <= ready_d;
      out_valid <= out_valid_d;
      out_sum   <= out_sum_d;
      out_count <= out_count_d;
      out_ovf   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_mac_unit.sv
// Bench for sm_mac_unit: default instance plus a narrow ACC_W=32 / MAX_LEN=4 instance.
module tb_sm_mac_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, out_ready, in_last;
  logic [15:0] in_a, in_b;
  logic        iv_b, iv_s, rdy_b, rdy_s, ov_b, ov_s, ovf_b, ovf_s;
  logic [39:0] sum_b;
  logic [31:0] sum_s;
  logic [9:0]  cnt_b;
  logic [2:0]  cnt_s;

  sm_mac_unit u_big (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_b), .in_ready(rdy_b),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  sm_mac_unit #(.BIT(16), .ACC_W(32), .MAX_LEN(4)) u_small (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv_s), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready),
    .out_sum(sum_s), .out_count(cnt_s), .out_ovf(ovf_s)
  );

  typedef struct packed {
    logic        sel;
    logic [2:0]  n;
    logic        last;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] es;
    logic [9:0]  ec;
    logic        eo;
  } vec_t;

`ifdef SM_MAC_RELU_EN
  localparam logic [63:0] Neg4B    = 64'd0;
  localparam logic [63:0] Neg15B   = 64'd0;
  localparam logic [63:0] NegMixB  = 64'd0;
  localparam logic [63:0] NegSatS  = 64'd0;
`else
  localparam logic [63:0] Neg4B    = (64'd1 << 39) | 64'd4;
  localparam logic [63:0] Neg15B   = (64'd1 << 39) | 64'd15;
  localparam logic [63:0] NegMixB  = (64'd1 << 39) | 64'd229356;
  localparam logic [63:0] NegSatS  = 64'hFFFF_FFFF;
`endif

  int          nvec = 0;
  int          nfail = 0;
  logic [15:0] ba [8];
  logic [15:0] bb [8];
  vec_t        tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(int sel);
    return (sel != 0) ? rdy_s : rdy_b;
  endfunction
  function automatic logic ovalid(int sel);
    return (sel != 0) ? ov_s : ov_b;
  endfunction

  function automatic vec_t mk(logic sel, logic [2:0] n, logic last, logic [63:0] a,
                              logic [63:0] b, logic [63:0] es, logic [9:0] ec, logic eo);
    vec_t v;
    v.sel = sel; v.n = n; v.last = last; v.a = a; v.b = b; v.es = es; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  // Spec-level product of two sign-magnitude codes.
  function automatic longint prod(logic [15:0] a, logic [15:0] b);
    longint am, bm, s;
    am = longint'(a[14:0]);
    bm = longint'(b[14:0]);
    if (a == 16'h0 || b == 16'h0) return 0;
    if (a == 16'h8000 && b == 16'h8000) return 32768;
    if (a == 16'h8000) return b[15] ? -(bm * 32768) : bm * 32768;
    if (b == 16'h8000) return a[15] ? -(am * 32768) : am * 32768;
    s = am * bm;
    return (a[15] ^ b[15]) ? -s : s;
  endfunction

  task automatic model(input int n, input int accw, output logic [63:0] es, output logic eo);
    longint acc, lim;
    acc = 0;
    lim = (longint'(1) << (accw - 1)) - 1;
    eo  = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += prod(ba[i], bb[i]);
      if (acc > lim) begin acc = lim; eo = 1'b1; end
      else if (acc < -lim) begin acc = -lim; eo = 1'b1; end
    end
    if (acc < 0) begin
`ifdef SM_MAC_RELU_EN
      es = 64'd0;
`else
      es = (64'd1 << (accw - 1)) | 64'(-acc);
`endif
    end else begin
      es = 64'(acc);
    end
  endtask

  // Entered at a negedge; returns just after the posedge that accepts the final beat.
  task automatic send_beats(input int sel, input int n, input logic with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_a    = ba[i];
      in_b    = bb[i];
      in_last = with_last && (i == n - 1);
      if (sel != 0) iv_s = 1'b1; else iv_b = 1'b1;
      guard = 0;
      while (!rdy(sel) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("ready_timeout", 64'(rdy(sel)), 64'd1);
      @(posedge clk);
      if (i != n - 1) @(negedge clk);
    end
  endtask

  task automatic collect(input int sel, input string name, input logic [63:0] es,
                         input logic [63:0] ec, input logic eo);
    int lat;
    @(negedge clk);
    iv_b = 1'b0; iv_s = 1'b0; in_last = 1'b0;
    lat = 0;
    while (!ovalid(sel) && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(lat), 64'd2);
    if (sel != 0) begin
      check({name, "_sum"}, 64'(sum_s), es);
      check({name, "_count"}, 64'(cnt_s), ec);
      check({name, "_ovf"}, 64'(ovf_s), 64'(eo));
    end else begin
      check({name, "_sum"}, 64'(sum_b), es);
      check({name, "_count"}, 64'(cnt_b), ec);
      check({name, "_ovf"}, 64'(ovf_b), 64'(eo));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_after_take"}, 64'(ovalid(sel)), 64'd0);
  endtask

  task automatic wait_valid_big();
    int guard;
    @(negedge clk);
    iv_b = 1'b0; in_last = 1'b0;
    guard = 0;
    while (!ov_b && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("valid_timeout", 64'(ov_b), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] es;
    logic        eo;
    int          n;

    tbl[0]  = mk(1'b0, 3'd1, 1'b1, 64'h0003, 64'h0004, 64'd12, 10'd1, 1'b0);
    tbl[1]  = mk(1'b0, 3'd2, 1'b1, 64'h0003_8003, 64'h0004_0004, 64'd0, 10'd2, 1'b0);
    tbl[2]  = mk(1'b0, 3'd1, 1'b1, 64'h8000, 64'h0005, 64'd163840, 10'd1, 1'b0);
    tbl[3]  = mk(1'b0, 3'd1, 1'b1, 64'h8000, 64'h8000, 64'd32768, 10'd1, 1'b0);
    tbl[4]  = mk(1'b0, 3'd1, 1'b1, 64'h8002, 64'h0002, Neg4B, 10'd1, 1'b0);
    tbl[5]  = mk(1'b0, 3'd1, 1'b1, 64'h0000, 64'h8000, 64'd0, 10'd1, 1'b0);
    tbl[6]  = mk(1'b0, 3'd1, 1'b1, 64'h0005, 64'h8003, Neg15B, 10'd1, 1'b0);
    tbl[7]  = mk(1'b0, 3'd2, 1'b1, 64'h0004_8000, 64'h0005_8007, NegMixB, 10'd2, 1'b0);
    tbl[8]  = mk(1'b1, 3'd3, 1'b1, 64'h7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF,
                 64'h7FFF_FFFF, 10'd3, 1'b1);
    tbl[9]  = mk(1'b1, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF,
                 NegSatS, 10'd3, 1'b1);
    tbl[10] = mk(1'b1, 3'd4, 1'b0, 64'h0001_0001_0001_0001, 64'h0004_0003_0002_0001,
                 64'd10, 10'd4, 1'b0);

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv_b = 1'b0; iv_s = 1'b0;
    in_a = '0; in_b = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_big", 64'(rdy_b), 64'd0);
    check("rst_ready_small", 64'(rdy_s), 64'd0);
    check("rst_valid", 64'(ov_b), 64'd0);
    check("rst_sum", 64'(sum_b), 64'd0);
    check("rst_count", 64'(cnt_b), 64'd0);
    check("rst_ovf", 64'(ovf_b), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_before_first_edge", 64'(rdy_b), 64'd0);
    @(negedge clk);
    check("ready_after_first_edge", 64'(rdy_b), 64'd1);

    // Table vectors run back to back: each starts the cycle after the previous handshake.
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 4; k++) begin
        ba[k] = tbl[i].a[k*16 +: 16];
        bb[k] = tbl[i].b[k*16 +: 16];
      end
      send_beats(int'(tbl[i].sel), int'(tbl[i].n), tbl[i].last);
      collect(int'(tbl[i].sel), $sformatf("vec%0d", i), tbl[i].es, 64'(tbl[i].ec), tbl[i].eo);
    end

    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        for (int side = 0; side < 2; side++) begin
          logic [15:0] op;
          case ($urandom_range(0, 9))
            0:       op = 16'h0000;
            1:       op = 16'h8000;
            2:       op = 16'(($urandom_range(0, 1) << 15) | $urandom_range(1, 20));
            default: op = 16'($urandom);
          endcase
          if (side == 0) ba[k] = op; else bb[k] = op;
        end
      end
      model(n, 40, es, eo);
      send_beats(0, n, 1'b1);
      collect(0, $sformatf("rand_big%0d", r), es, 64'(n), eo);
    end

    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        ba[k] = 16'($urandom) | 16'h7000;
        bb[k] = 16'($urandom) | 16'h7000;
      end
      model(n, 32, es, eo);
      send_beats(1, n, 1'b1);
      collect(1, $sformatf("rand_small%0d", r), es, 64'(n), eo);
    end

    // Backpressure: result must hold while out_ready stays low.
    ba[0] = 16'h0003; bb[0] = 16'h0004;
    send_beats(0, 1, 1'b1);
    wait_valid_big();
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 64'(ov_b), 64'd1);
      check("hold_sum", 64'(sum_b), 64'd12);
      check("hold_ready", 64'(rdy_b), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("take_valid", 64'(ov_b), 64'd0);
    check("take_ready", 64'(rdy_b), 64'd1);
    ba[0] = 16'h0002; bb[0] = 16'h0002;
    send_beats(0, 1, 1'b1);
    collect(0, "after_hold", 64'd4, 64'd1, 1'b0);

    // Flush mid-vector; the beat presented alongside flush is dropped.
    ba[0] = 16'h0005; bb[0] = 16'h0005; ba[1] = 16'h0006; bb[1] = 16'h0006;
    send_beats(0, 2, 1'b0);
    @(negedge clk);
    in_a = 16'h0009; in_b = 16'h0009; iv_b = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; iv_b = 1'b0;
    check("flush_ready", 64'(rdy_b), 64'd1);
    check("flush_valid", 64'(ov_b), 64'd0);
    ba[0] = 16'h0001; bb[0] = 16'h0007;
    send_beats(0, 1, 1'b1);
    collect(0, "after_flush", 64'd7, 64'd1, 1'b0);

    // Flush while a result is held drops it.
    ba[0] = 16'h0003; bb[0] = 16'h0004;
    send_beats(0, 1, 1'b1);
    wait_valid_big();
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_held_valid", 64'(ov_b), 64'd0);
    check("flush_held_sum", 64'(sum_b), 64'd0);
    check("flush_held_count", 64'(cnt_b), 64'd0);
    ba[0] = 16'h0002; bb[0] = 16'h0003;
    send_beats(0, 1, 1'b1);
    collect(0, "after_flush_held", 64'd6, 64'd1, 1'b0);

    // Asynchronous reset mid-vector.
    ba[0] = 16'h0007; bb[0] = 16'h0007;
    send_beats(0, 1, 1'b0);
    @(negedge clk);
    iv_b = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(rdy_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ba[0] = 16'h0001; bb[0] = 16'h0001;
    send_beats(0, 1, 1'b1);
    collect(0, "after_rst", 64'd1, 64'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
